// File: rtl/i2c_frame_arbiter.sv
// i2c_frame_arbiter
// Shares one I2C serializer between two frame sources: port 0 (init
// sequencer) and port 1 (runtime control). A request is accepted in S_IDLE,
// latched into a hold register, launched with a one-cycle o_tx_start once the
// serializer is free, and completed with a one-cycle done pulse to its owner.
// Priority swaps to the other port after every finished transaction, so two
// busy requesters alternate while a lone requester is served back-to-back.
//
// Optional feature: define I2C_ARB_TIMEOUT_EN to abandon a frame when the
// serializer does not report done within TIMEOUT_CYCLES. The abandoned frame
// still gets its done pulse, together with o_err, and o_timeout is set until
// reset. Without the macro, o_err and o_timeout are tied low.
//
// Ports:
//   i_clk, i_rst_n           clock (rising edge), async active-low reset
//   i_reqN_valid/frame       frame request from port N (N = 0, 1)
//   o_reqN_ready             port N request accepted this cycle
//   o_reqN_done              port N frame finished, 1-cycle pulse
//   o_tx_start, o_tx_frame   launch pulse and frame for the serializer
//   i_tx_busy, i_tx_done     serializer occupied / finished (pulse)
//   o_grant                  one-hot owner of the transaction, 0 when idle
//   o_err, o_timeout         abandon pulse (with done) and sticky flag
module i2c_frame_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req0_valid,
    input  logic [23:0] i_req0_frame,
    output logic        o_req0_ready,
    output logic        o_req0_done,
    input  logic        i_req1_valid,
    input  logic [23:0] i_req1_frame,
    output logic        o_req1_ready,
    output logic        o_req1_done,
    output logic        o_tx_start,
    output logic [23:0] o_tx_frame,
    input  logic        i_tx_busy,
    input  logic        i_tx_done,
    output logic [1:0]  o_grant,
    output logic        o_err,
    output logic        o_timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        prio_q, prio_d;      // 0: port 0 wins a tie, 1: port 1
    logic [23:0] hold_q, hold_d;
    logic [1:0]  grant_q, grant_d;

    logic        sel;
    logic        ready0, ready1;
    logic        tx_start;
    logic        done0, done1;

`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
    logic        err_q, err_d;         // current transaction was abandoned
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            prio_q    <= 1'b0;
            hold_q    <= 24'h0;
            grant_q   <= 2'b00;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q     <= 16'h0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        hold_d    = hold_q;
        grant_d   = grant_q;
        ready0    = 1'b0;
        ready1    = 1'b0;
        tx_start  = 1'b0;
        done0     = 1'b0;
        done1     = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        err_d     = err_q;
`endif

        // A lone requester is always selected; a tie (or no request) goes
        // to the priority holder so exactly one ready is shown in S_IDLE.
        sel = prio_q;
        if (i_req0_valid && !i_req1_valid) begin
            sel = 1'b0;
        end else if (i_req1_valid && !i_req0_valid) begin
            sel = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                ready0 = !sel;
                ready1 = sel;
                if (!sel && i_req0_valid) begin
                    hold_d  = i_req0_frame;
                    grant_d = 2'b01;
                    state_d = S_ISSUE;
                end else if (sel && i_req1_valid) begin
                    hold_d  = i_req1_frame;
                    grant_d = 2'b10;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!i_tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = S_WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
                    cnt_d    = 16'h0;
`endif
                end
            end
            S_WAIT: begin
                if (i_tx_done) begin
                    state_d = S_DONE;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else begin
                    // Compare the incremented count so S_DONE is reached
                    // TIMEOUT_CYCLES cycles after the launch pulse.
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_d == TIMEOUT_CYCLES - 16'd1) begin
                        state_d   = S_DONE;
                        err_d     = 1'b1;
                        timeout_d = 1'b1;
                    end
                end
`endif
            end
            S_DONE: begin
                done0   = grant_q[0];
                done1   = grant_q[1];
                prio_d  = grant_q[0];
                grant_d = 2'b00;
                state_d = S_IDLE;
`ifdef I2C_ARB_TIMEOUT_EN
                err_d   = 1'b0;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Ready is combinational from S_IDLE, so it is masked while reset is
    // held to keep every output low during reset.
    assign o_req0_ready = ready0 & i_rst_n;
    assign o_req1_ready = ready1 & i_rst_n;
    assign o_req0_done  = done0;
    assign o_req1_done  = done1;
    assign o_tx_start   = tx_start;
    assign o_tx_frame   = hold_q;
    assign o_grant      = grant_q;

`ifdef I2C_ARB_TIMEOUT_EN
    assign o_err        = (state_q == S_DONE) & err_q;
    assign o_timeout    = timeout_q;
`else
    assign o_err        = 1'b0;
    assign o_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_frame_arbiter.sv
// tb_i2c_frame_arbiter
// Directed bench for i2c_frame_arbiter. Stimulus pushes expected launches and
// completions into queues; a monitor pops and compares them whenever the DUT
// pulses o_tx_start or a done. A small serializer model answers each launch
// with i_tx_done after ser_delay cycles when enabled. Build with or without
// I2C_ARB_TIMEOUT_EN; the abandon scenario follows the macro.
module tb_i2c_frame_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_req0_valid = 1'b0;
    logic [23:0] i_req0_frame = 24'h0;
    logic        o_req0_ready;
    logic        o_req0_done;
    logic        i_req1_valid = 1'b0;
    logic [23:0] i_req1_frame = 24'h0;
    logic        o_req1_ready;
    logic        o_req1_done;
    logic        o_tx_start;
    logic [23:0] o_tx_frame;
    logic        i_tx_busy = 1'b0;
    logic        i_tx_done = 1'b0;
    logic [1:0]  o_grant;
    logic        o_err;
    logic        o_timeout;

    i2c_frame_arbiter #(.TIMEOUT_CYCLES(16'd8)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req0_valid(i_req0_valid),
        .i_req0_frame(i_req0_frame),
        .o_req0_ready(o_req0_ready),
        .o_req0_done (o_req0_done),
        .i_req1_valid(i_req1_valid),
        .i_req1_frame(i_req1_frame),
        .o_req1_ready(o_req1_ready),
        .o_req1_done (o_req1_done),
        .o_tx_start  (o_tx_start),
        .o_tx_frame  (o_tx_frame),
        .i_tx_busy   (i_tx_busy),
        .i_tx_done   (i_tx_done),
        .o_grant     (o_grant),
        .o_err       (o_err),
        .o_timeout   (o_timeout)
    );

    initial forever #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [23:0] frame;
        logic [1:0]  grant;
        logic [31:0] lat;     // cycles from acceptance to launch
    } start_exp_t;

    typedef struct packed {
        logic [1:0]  done;    // {req1_done, req0_done}
        logic        err;
        logic [31:0] lat;     // cycles from launch to done pulse
    } done_exp_t;

    start_exp_t start_q[$];
    done_exp_t  done_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int start_cyc = 0;
    int ser_delay = 3;
    bit ser_en = 1'b1;

    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic boundExpired(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: wait bound expired, got no event, expected one", name);
    endtask

    // Serializer model: answer a launch with a one-cycle i_tx_done.
    initial forever begin
        @(negedge i_clk);
        if (o_tx_start && ser_en) begin
            repeat (ser_delay) @(posedge i_clk);
            #1 i_tx_done = 1'b1;
            @(posedge i_clk);
            #1 i_tx_done = 1'b0;
        end
    end

    // Monitor: compares every launch and every done against the queues.
    initial begin
        start_exp_t se;
        done_exp_t  de;
        forever begin
            @(negedge i_clk);
            if ((i_req0_valid && o_req0_ready) || (i_req1_valid && o_req1_ready)) begin
                checkOutput("ready_onehot", {o_req1_ready, o_req0_ready},
                            (i_req0_valid && o_req0_ready) ? 2'b01 : 2'b10);
                acc_cyc = cyc;
            end
            if (o_tx_start) begin
                if (start_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_start: got frame %0h, expected no launch", o_tx_frame);
                end else begin
                    se = start_q.pop_front();
                    checkOutput("start_frame", o_tx_frame, se.frame);
                    checkOutput("start_grant", o_grant, se.grant);
                    checkOutput("start_latency", cyc - acc_cyc, se.lat);
                end
                start_cyc = cyc;
            end
            if (o_req0_done || o_req1_done || o_err) begin
                if (done_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_done: got done %0b err %0b, expected none",
                             {o_req1_done, o_req0_done}, o_err);
                end else begin
                    de = done_q.pop_front();
                    checkOutput("done_port", {o_req1_done, o_req0_done}, de.done);
                    checkOutput("done_err", o_err, de.err);
                    checkOutput("done_grant", o_grant, de.done);
                    checkOutput("done_latency", cyc - start_cyc, de.lat);
                end
            end
        end
    end

    // Issue one frame on a port and hold valid until it is accepted.
    task automatic applyStimulus(input int port, input logic [23:0] frame, input int start_lat,
                                 input int done_lat, input logic exp_err, input bit exp_done);
        logic [1:0] g;
        bit got;
        g = (port == 0) ? 2'b01 : 2'b10;
        start_q.push_back('{frame, g, start_lat});
        if (exp_done) done_q.push_back('{g, exp_err, done_lat});
        if (port == 0) begin
            i_req0_frame = frame;
            i_req0_valid = 1'b1;
        end else begin
            i_req1_frame = frame;
            i_req1_valid = 1'b1;
        end
        got = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge i_clk);
            if ((port == 0) ? o_req0_ready : o_req1_ready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge i_clk);
        #1;
        if (port == 0) i_req0_valid = 1'b0;
        else           i_req1_valid = 1'b0;
        if (!got) boundExpired("accept_wait");
    endtask

    // Both ports valid continuously, n frames each; expects strict alternation
    // starting with port 0.
    task automatic runBoth(input int n, input logic [23:0] base0, input logic [23:0] base1);
        int i0;
        int i1;
        bit a0;
        bit a1;
        for (int k = 0; k < n; k++) begin
            start_q.push_back('{base0 + 24'(k), 2'b01, 32'd1});
            start_q.push_back('{base1 + 24'(k), 2'b10, 32'd1});
            done_q.push_back('{2'b01, 1'b0, 32'(ser_delay + 1)});
            done_q.push_back('{2'b10, 1'b0, 32'(ser_delay + 1)});
        end
        i0 = 0;
        i1 = 0;
        i_req0_frame = base0;
        i_req1_frame = base1;
        i_req0_valid = 1'b1;
        i_req1_valid = 1'b1;
        for (int c = 0; c < 2000 && (i0 < n || i1 < n); c++) begin
            @(negedge i_clk);
            a0 = i_req0_valid && o_req0_ready;
            a1 = i_req1_valid && o_req1_ready;
            @(posedge i_clk);
            #1;
            if (a0) begin
                i0++;
                if (i0 < n) i_req0_frame = base0 + 24'(i0);
                else        i_req0_valid = 1'b0;
            end
            if (a1) begin
                i1++;
                if (i1 < n) i_req1_frame = base1 + 24'(i1);
                else        i_req1_valid = 1'b0;
            end
        end
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        if (i0 < n || i1 < n) boundExpired("both_accept_wait");
    endtask

    // Wait until every expected event has been seen and the arbiter is idle.
    task automatic waitDrain(input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge i_clk);
            if (start_q.size() == 0 && done_q.size() == 0 && o_grant == 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) boundExpired(name);
        else tests++;
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [34:0] allOutputs();
        return {o_req0_ready, o_req1_ready, o_req0_done, o_req1_done, o_tx_start,
                o_grant, o_err, o_timeout, o_tx_frame};
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end of run, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge i_clk);
        checkOutput("reset_outputs", allOutputs(), 35'h0);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        @(negedge i_clk);
        checkOutput("idle_ready_prio0", {o_req0_ready, o_req1_ready}, 2'b10);
        @(posedge i_clk);
        #1;

        // Single frame on port 0, done 20 cycles after launch
        ser_delay = 20;
        applyStimulus(0, 24'h340097, 1, 21, 1'b0, 1'b1);
        waitDrain("drain_basic");
        checkOutput("frame_held_idle", o_tx_frame, 24'h340097);
        ser_delay = 3;

        // Lone requester served back-to-back
        applyStimulus(0, 24'h123456, 1, 4, 1'b0, 1'b1);
        applyStimulus(0, 24'h2345AB, 1, 4, 1'b0, 1'b1);
        waitDrain("drain_b2b");

        // Stray i_tx_done in S_IDLE: no done, no state change
        i_tx_done = 1'b1;
        @(posedge i_clk);
        #1 i_tx_done = 1'b0;
        @(negedge i_clk);
        checkOutput("stray_done_grant", o_grant, 2'b00);
        checkOutput("stray_done_ready", {o_req0_ready, o_req1_ready}, 2'b01);
        @(posedge i_clk);
        #1;

        // Serializer busy for 10 cycles after acceptance
        i_tx_busy = 1'b1;
        fork
            applyStimulus(1, 24'h5A1234, 11, 4, 1'b0, 1'b1);
            begin
                for (int c = 0; c < 300; c++) begin
                    @(negedge i_clk);
                    if (i_req1_valid && o_req1_ready) break;
                end
                repeat (11) @(posedge i_clk);
                #1 i_tx_busy = 1'b0;
            end
        join
        waitDrain("drain_busy");

        // Serializer never answers
        ser_en = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
        applyStimulus(1, 24'h7F0F0F, 1, 8, 1'b1, 1'b1);
        waitDrain("drain_timeout");
        checkOutput("timeout_sticky", o_timeout, 1'b1);
        ser_en = 1'b1;
        applyStimulus(0, 24'h0C0C0C, 1, 4, 1'b0, 1'b1);
        waitDrain("drain_after_timeout");
        checkOutput("timeout_still_set", o_timeout, 1'b1);
        ser_en = 1'b0;
        applyStimulus(0, 24'h111111, 1, 0, 1'b0, 1'b0);
        repeat (3) @(negedge i_clk);
        checkOutput("in_wait_grant", o_grant, 2'b01);
`else
        applyStimulus(1, 24'h7F0F0F, 1, 0, 1'b0, 1'b0);
        repeat (30) @(negedge i_clk);
        checkOutput("stuck_wait_grant", o_grant, 2'b10);
        checkOutput("stuck_wait_ready", {o_req0_ready, o_req1_ready}, 2'b00);
        checkOutput("no_timeout_flag", {o_timeout, o_err}, 2'b00);
`endif

        // Reset during S_WAIT with both ports requesting
        @(posedge i_clk);
        #1;
        i_req0_frame = 24'hA00001;
        i_req1_frame = 24'hB00001;
        i_req0_valid = 1'b1;
        i_req1_valid = 1'b1;
        i_rst_n = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            checkOutput("reset_mid_outputs", allOutputs(), 35'h0);
        end
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        ser_en = 1'b1;
        runBoth(1, 24'hA00001, 24'hB00001);
        waitDrain("drain_after_reset");

        // Both ports valid continuously, three frames each
        runBoth(3, 24'hC00010, 24'hD00020);
        waitDrain("drain_alternate");

        checkOutput("start_queue_empty", start_q.size(), 0);
        checkOutput("done_queue_empty", done_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
